// File: rtl/axi_lite_master_bridge_pkg.sv
// Shared AXI4-lite definitions: response codes, prot bit positions and the
// bridge state encoding.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int PROT_PRIV_BIT  = 0;
    localparam int PROT_NSEC_BIT  = 1;
    localparam int PROT_INSTR_BIT = 2;

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_REQ,
        WR_RESP
    } bridge_state_e;

    // Unprivileged, secure; only the data/instruction bit varies.
    function automatic logic [2:0] make_prot(input logic instr);
        logic [2:0] p;
        p                 = '0;
        p[PROT_PRIV_BIT]  = 1'b0;
        p[PROT_NSEC_BIT]  = 1'b0;
        p[PROT_INSTR_BIT] = instr;
        return p;
    endfunction

    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
    endfunction

endpackage

// File: rtl/axi_lite_master_bridge_if.sv
// Bundle of the core request port and the AXI4-lite master channels.
// master = bridge side, slave = memory/bench side.
interface axi_lite_master_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_W-1:0]     req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic [DATA_W/8-1:0]   req_wstrb;
    logic                  req_instr;
    logic                  rsp_valid;
    logic [DATA_W-1:0]     rsp_rdata;
    logic                  rsp_err;

    logic                  awvalid;
    logic                  awready;
    logic [ADDR_W-1:0]     awaddr;
    logic [2:0]            awprot;
    logic                  wvalid;
    logic                  wready;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   wstrb;
    logic                  bvalid;
    logic                  bready;
    logic [1:0]            bresp;
    logic                  arvalid;
    logic                  arready;
    logic [ADDR_W-1:0]     araddr;
    logic [2:0]            arprot;
    logic                  rvalid;
    logic                  rready;
    logic [DATA_W-1:0]     rdata;
    logic [1:0]            rresp;

    modport master (
        input  req_valid, req_addr, req_wdata, req_wstrb, req_instr,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
        output arvalid, araddr, arprot, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        output req_valid, req_addr, req_wdata, req_wstrb, req_instr,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
        input  arvalid, araddr, arprot, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/axi_lite_master_bridge_props.sv
// AXI4-lite master protocol properties, compiled only when
// AXI_LITE_MASTER_ASSERT_EN is defined.
`ifdef AXI_LITE_MASTER_ASSERT_EN
module axi_lite_master_props (
    input logic                     clk,
    input logic                     resetn,
    axi_lite_master_bridge_if.master bus
);
    logic busy_q, ar_seen_q, aw_seen_q, w_seen_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            busy_q    <= 1'b0;
            ar_seen_q <= 1'b0;
            aw_seen_q <= 1'b0;
            w_seen_q  <= 1'b0;
        end else begin
            if (bus.req_valid && bus.req_ready) busy_q <= 1'b1;
            else if (bus.rsp_valid)             busy_q <= 1'b0;
            if (bus.arvalid && bus.arready)     ar_seen_q <= 1'b1;
            else if (bus.rvalid && bus.rready)  ar_seen_q <= 1'b0;
            if (bus.bvalid && bus.bready) begin
                aw_seen_q <= 1'b0;
                w_seen_q  <= 1'b0;
            end else begin
                if (bus.awvalid && bus.awready) aw_seen_q <= 1'b1;
                if (bus.wvalid && bus.wready)   w_seen_q  <= 1'b1;
            end
        end
    end

    ap_ar_hold: assert property (@(posedge clk) disable iff (!resetn)
        (bus.arvalid && !bus.arready) |=> (bus.arvalid && $stable(bus.araddr) && $stable(bus.arprot)));
    ap_aw_hold: assert property (@(posedge clk) disable iff (!resetn)
        (bus.awvalid && !bus.awready) |=> (bus.awvalid && $stable(bus.awaddr) && $stable(bus.awprot)));
    ap_w_hold: assert property (@(posedge clk) disable iff (!resetn)
        (bus.wvalid && !bus.wready) |=> (bus.wvalid && $stable(bus.wdata) && $stable(bus.wstrb)));
    ap_one_outstanding: assert property (@(posedge clk) disable iff (!resetn)
        !(busy_q && bus.req_ready));
    ap_ar_aw_excl: assert property (@(posedge clk) disable iff (!resetn)
        !(bus.arvalid && bus.awvalid));
    ap_rsp_pulse: assert property (@(posedge clk) disable iff (!resetn)
        bus.rsp_valid |=> !bus.rsp_valid);

    am_r_after_ar: assume property (@(posedge clk) disable iff (!resetn)
        bus.rvalid |-> ar_seen_q);
    am_b_after_aw_w: assume property (@(posedge clk) disable iff (!resetn)
        bus.bvalid |-> (aw_seen_q && w_seen_q));
endmodule
`endif

// File: rtl/axi_lite_master_bridge.sv
// Single-outstanding core memory port to AXI4-lite master bridge.
// Define AXI_LITE_MASTER_ASSERT_EN to compile in the protocol properties.
module axi_lite_master_bridge
    import axi_lite_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input logic                      clk,
    input logic                      resetn,
    axi_lite_master_bridge_if.master bus
);
    localparam int STRB_W = DATA_W / 8;

    bridge_state_e     state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [STRB_W-1:0] wstrb_q;
    logic [2:0]        prot_q;
    logic [DATA_W-1:0] rdata_q;
    logic              arvalid_q, rready_q, awvalid_q, wvalid_q, bready_q;
    logic              rsp_valid_q, rsp_err_q;
    logic              req_ready, aw_done_d, w_done_d;

    // Holding req_ready low in the response cycle keeps exactly one request in flight.
    assign req_ready = (state_q == IDLE) && !rsp_valid_q;
    assign aw_done_d = !awvalid_q || bus.awready;
    assign w_done_d  = !wvalid_q || bus.wready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            prot_q      <= '0;
            rdata_q     <= '0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                IDLE: if (bus.req_valid && req_ready) begin
                    addr_q  <= bus.req_addr;
                    wdata_q <= bus.req_wdata;
                    wstrb_q <= bus.req_wstrb;
                    prot_q  <= make_prot(bus.req_instr);
                    if (|bus.req_wstrb) begin
                        state_q   <= WR_REQ;
                        awvalid_q <= 1'b1;
                        wvalid_q  <= 1'b1;
                    end else begin
                        state_q   <= RD_ADDR;
                        arvalid_q <= 1'b1;
                    end
                end
                RD_ADDR: if (bus.arready) begin
                    arvalid_q <= 1'b0;
                    rready_q  <= 1'b1;
                    state_q   <= RD_DATA;
                end
                RD_DATA: if (bus.rvalid) begin
                    rready_q    <= 1'b0;
                    rdata_q     <= bus.rdata;
                    rsp_err_q   <= resp_is_err(bus.rresp);
                    rsp_valid_q <= 1'b1;
                    state_q     <= IDLE;
                end
                // AW and W complete independently; either may finish first.
                WR_REQ: begin
                    if (bus.awready) awvalid_q <= 1'b0;
                    if (bus.wready)  wvalid_q  <= 1'b0;
                    if (aw_done_d && w_done_d) begin
                        bready_q <= 1'b1;
                        state_q  <= WR_RESP;
                    end
                end
                WR_RESP: if (bus.bvalid) begin
                    bready_q    <= 1'b0;
                    rsp_err_q   <= resp_is_err(bus.bresp);
                    rsp_valid_q <= 1'b1;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.arvalid   = arvalid_q;
    assign bus.araddr    = addr_q;
    assign bus.arprot    = prot_q;
    assign bus.rready    = rready_q;
    assign bus.awvalid   = awvalid_q;
    assign bus.awaddr    = addr_q;
    assign bus.awprot    = prot_q;
    assign bus.wvalid    = wvalid_q;
    assign bus.wdata     = wdata_q;
    assign bus.wstrb     = wstrb_q;
    assign bus.bready    = bready_q;

`ifdef AXI_LITE_MASTER_ASSERT_EN
    axi_lite_master_props u_props (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );
`else
    // Protocol properties compiled out.
`endif
endmodule

// File: tb/tb_axi_lite_master_bridge.sv
// Bench for axi_lite_master_bridge: delay-programmable slave, handshake-level
// reference model checked every cycle, directed cycle-exact scenarios, random traffic.
module tb_axi_lite_master_bridge;
    import axi_lite_pkg::*;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    axi_lite_master_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    axi_lite_master_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int total = 0;
    int bad   = 0;

    int ar_dly = 0, aw_dly = 0, w_dly = 0, r_dly = 0, b_dly = 0;
    logic [31:0] nxt_rdata = 32'h0;
    logic [1:0]  nxt_rresp = RESP_OKAY;
    logic [1:0]  nxt_bresp = RESP_OKAY;

    task automatic check_b(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_w(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Call just after a rising edge; returns one edge after acceptance.
    task automatic issue(input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic ins);
        int n;
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        bus.req_wdata = d;
        bus.req_wstrb = s;
        bus.req_instr = ins;
        n = 0;
        while (n < 200) begin
            @(negedge clk);
            if (bus.req_ready) break;
            n++;
        end
        check_b("issue_accept", bus.req_ready, 1'b1);
        step();
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        int n;
        n = 0;
        while (n < 200) begin
            @(negedge clk);
            if (bus.rsp_valid) break;
            n++;
        end
        check_b("rsp_arrive", bus.rsp_valid, 1'b1);
    endtask

    // Slave: each ready rises after its valid has waited *_dly cycles.
    initial begin : slave
        int ar_c, aw_c, w_c, r_c, b_c;
        bit r_pend, aw_got, w_got, arf, awf, wf, rf, bf;
        ar_c = 0; aw_c = 0; w_c = 0; r_c = 0; b_c = 0;
        r_pend = 0; aw_got = 0; w_got = 0;
        bus.arready = 0; bus.awready = 0; bus.wready = 0;
        bus.rvalid = 0; bus.bvalid = 0; bus.rdata = '0; bus.rresp = '0; bus.bresp = '0;
        forever begin
            @(negedge clk);
            arf = resetn && bus.arvalid && bus.arready;
            awf = resetn && bus.awvalid && bus.awready;
            wf  = resetn && bus.wvalid && bus.wready;
            rf  = resetn && bus.rvalid && bus.rready;
            bf  = resetn && bus.bvalid && bus.bready;
            step();
            if (!resetn) begin
                ar_c = 0; aw_c = 0; w_c = 0; r_c = 0; b_c = 0;
                r_pend = 0; aw_got = 0; w_got = 0;
                bus.arready = 0; bus.awready = 0; bus.wready = 0;
                bus.rvalid = 0; bus.bvalid = 0;
            end else begin
                if (arf) begin
                    r_pend = 1; r_c = 0;
                    bus.rdata = nxt_rdata;
                    bus.rresp = nxt_rresp;
                end
                if (rf) r_pend = 0;
                if (awf) aw_got = 1;
                if (wf) w_got = 1;
                if (bf) begin aw_got = 0; w_got = 0; end
                if (bus.arvalid) begin bus.arready = (ar_c >= ar_dly); ar_c++; end
                else begin bus.arready = 0; ar_c = 0; end
                if (bus.awvalid) begin bus.awready = (aw_c >= aw_dly); aw_c++; end
                else begin bus.awready = 0; aw_c = 0; end
                if (bus.wvalid) begin bus.wready = (w_c >= w_dly); w_c++; end
                else begin bus.wready = 0; w_c = 0; end
                if (r_pend) begin bus.rvalid = (r_c >= r_dly); r_c++; end
                else bus.rvalid = 0;
                if (aw_got && w_got) begin
                    if (b_c == 0) bus.bresp = nxt_bresp;
                    bus.bvalid = (b_c >= b_dly); b_c++;
                end else begin
                    bus.bvalid = 0; b_c = 0;
                end
            end
        end
    end

    // Reference model: one request in flight, tracked by which handshakes are done.
    initial begin : model
        bit busy, act, wr, ar_d, aw_d, w_d, due, err;
        logic [31:0] addr, wdat, rdat;
        logic [3:0]  strb;
        logic [2:0]  prot;
        busy = 0; act = 0; wr = 0; ar_d = 0; aw_d = 0; w_d = 0; due = 0; err = 0;
        addr = '0; wdat = '0; rdat = '0; strb = '0; prot = '0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                busy = 0; act = 0; due = 0; err = 0; rdat = '0;
                ar_d = 0; aw_d = 0; w_d = 0;
            end else begin
                check_b("m_req_ready", bus.req_ready, !busy);
                check_b("m_arvalid", bus.arvalid, act && !wr && !ar_d);
                check_b("m_awvalid", bus.awvalid, act && wr && !aw_d);
                check_b("m_wvalid", bus.wvalid, act && wr && !w_d);
                check_b("m_rready", bus.rready, act && !wr && ar_d);
                check_b("m_bready", bus.bready, act && wr && aw_d && w_d);
                check_b("m_rsp_valid", bus.rsp_valid, due);
                check_w("m_rsp_rdata", bus.rsp_rdata, rdat);
                if (bus.rsp_valid) check_b("m_rsp_err", bus.rsp_err, err);
                if (bus.arvalid) begin
                    check_w("m_araddr", bus.araddr, addr);
                    check_w("m_arprot", 32'(bus.arprot), 32'(prot));
                end
                if (bus.awvalid) begin
                    check_w("m_awaddr", bus.awaddr, addr);
                    check_w("m_awprot", 32'(bus.awprot), 32'(prot));
                end
                if (bus.wvalid) begin
                    check_w("m_wdata", bus.wdata, wdat);
                    check_w("m_wstrb", 32'(bus.wstrb), 32'(strb));
                end
                if (due) busy = 0;
                due = 0;
                if (bus.req_valid && bus.req_ready) begin
                    busy = 1; act = 1;
                    addr = bus.req_addr; wdat = bus.req_wdata; strb = bus.req_wstrb;
                    wr   = (bus.req_wstrb != 4'b0000);
                    prot = {bus.req_instr, 2'b00};
                    ar_d = 0; aw_d = 0; w_d = 0;
                end else if (act) begin
                    if (bus.arvalid && bus.arready) ar_d = 1;
                    if (bus.awvalid && bus.awready) aw_d = 1;
                    if (bus.wvalid && bus.wready) w_d = 1;
                    if (bus.rvalid && bus.rready) begin
                        act = 0; due = 1; rdat = bus.rdata; err = bus.rresp[1];
                    end
                    if (bus.bvalid && bus.bready) begin
                        act = 0; due = 1; err = bus.bresp[1];
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation did not finish, total=%0d", total);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int n;
        logic [3:0] s;
        bus.req_valid = 0; bus.req_addr = '0; bus.req_wdata = '0;
        bus.req_wstrb = '0; bus.req_instr = 0;

        // Reset values
        repeat (3) @(negedge clk);
        check_b("rst_arvalid", bus.arvalid, 1'b0);
        check_b("rst_awvalid", bus.awvalid, 1'b0);
        check_b("rst_wvalid", bus.wvalid, 1'b0);
        check_b("rst_rready", bus.rready, 1'b0);
        check_b("rst_bready", bus.bready, 1'b0);
        check_b("rst_rsp_valid", bus.rsp_valid, 1'b0);
        check_b("rst_rsp_err", bus.rsp_err, 1'b0);
        check_w("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
        check_w("rst_araddr", bus.araddr, 32'h0);
        check_w("rst_wdata", bus.wdata, 32'h0);
        #2 resetn = 1'b1;
        step();

        // Zero-wait read
        nxt_rdata = 32'hDEAD_BEEF; nxt_rresp = RESP_OKAY;
        issue(32'h0000_1000, 32'h0, 4'b0000, 1'b0);
        @(negedge clk);
        check_b("t1_arvalid_c1", bus.arvalid, 1'b1);
        check_w("t1_araddr_c1", bus.araddr, 32'h0000_1000);
        @(negedge clk);
        check_b("t1_rsp_c2", bus.rsp_valid, 1'b0);
        @(negedge clk);
        check_b("t1_rsp_c3", bus.rsp_valid, 1'b1);
        check_w("t1_rdata", bus.rsp_rdata, 32'hDEAD_BEEF);
        check_b("t1_err", bus.rsp_err, 1'b0);
        @(negedge clk);
        check_b("t1_ready_c4", bus.req_ready, 1'b1);
        step();

        // Write, W handshake in cycle 1, AW in cycle 4
        aw_dly = 3;
        issue(32'h0000_0020, 32'h1234_5678, 4'b0011, 1'b0);
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            check_b("t2_awvalid", bus.awvalid, c <= 4);
            check_b("t2_wvalid", bus.wvalid, c == 1);
            check_b("t2_bready", bus.bready, c == 5);
            check_b("t2_rsp_valid", bus.rsp_valid, c == 6);
            if (c == 1) begin
                check_w("t2_wdata", bus.wdata, 32'h1234_5678);
                check_w("t2_wstrb", 32'(bus.wstrb), 32'h3);
            end
        end
        check_w("t2_rdata_kept", bus.rsp_rdata, 32'hDEAD_BEEF);
        aw_dly = 0;
        step();

        // AR stall for 10 cycles on an instruction fetch
        ar_dly = 10; nxt_rdata = 32'hCAFE_0001;
        issue(32'h0000_0044, 32'h0, 4'b0000, 1'b1);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            check_b("t3_arvalid", bus.arvalid, 1'b1);
            check_w("t3_araddr", bus.araddr, 32'h0000_0044);
            check_w("t3_arprot", 32'(bus.arprot), 32'h4);
            check_b("t3_req_ready", bus.req_ready, 1'b0);
        end
        wait_rsp();
        check_w("t3_rdata", bus.rsp_rdata, 32'hCAFE_0001);
        ar_dly = 0;
        step();

        // SLVERR on write leaves read data untouched
        nxt_bresp = RESP_SLVERR;
        issue(32'h0000_0080, 32'hFFFF_0000, 4'b1111, 1'b0);
        repeat (3) @(negedge clk);
        check_b("t4_rsp_valid", bus.rsp_valid, 1'b1);
        check_b("t4_err", bus.rsp_err, 1'b1);
        check_w("t4_rdata_kept", bus.rsp_rdata, 32'hCAFE_0001);
        nxt_bresp = RESP_OKAY;
        step();

        // Instruction read then write held pending back to back
        nxt_rdata = 32'h600D_F00D;
        issue(32'h0000_0100, 32'h0, 4'b0000, 1'b1);
        bus.req_valid = 1'b1; bus.req_addr = 32'h0000_0104;
        bus.req_wdata = 32'hA5A5_A5A5; bus.req_wstrb = 4'b1111; bus.req_instr = 1'b0;
        @(negedge clk);
        check_w("t5_arprot", 32'(bus.arprot), 32'h4);
        @(negedge clk);
        check_b("t5_ready_c2", bus.req_ready, 1'b0);
        @(negedge clk);
        check_b("t5_rsp_c3", bus.rsp_valid, 1'b1);
        check_b("t5_ready_c3", bus.req_ready, 1'b0);
        check_w("t5_rdata", bus.rsp_rdata, 32'h600D_F00D);
        @(negedge clk);
        check_b("t5_ready_c4", bus.req_ready, 1'b1);
        step();
        bus.req_valid = 1'b0;
        @(negedge clk);
        check_b("t5_awvalid", bus.awvalid, 1'b1);
        check_w("t5_awprot", 32'(bus.awprot), 32'h0);
        check_w("t5_awaddr", bus.awaddr, 32'h0000_0104);
        wait_rsp();
        check_b("t5_err", bus.rsp_err, 1'b0);
        step();

        // Reset while AW/W are waiting
        aw_dly = 5; w_dly = 5;
        issue(32'h0000_0200, 32'h1111_1111, 4'b0001, 1'b0);
        @(negedge clk);
        check_b("t6_awvalid_pre", bus.awvalid, 1'b1);
        @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        check_b("t6_awvalid_async", bus.awvalid, 1'b0);
        check_b("t6_wvalid_async", bus.wvalid, 1'b0);
        check_w("t6_awaddr_rst", bus.awaddr, 32'h0);
        repeat (2) @(negedge clk);
        #2 resetn = 1'b1;
        aw_dly = 0; w_dly = 0;
        @(negedge clk);
        check_b("t6_req_ready", bus.req_ready, 1'b1);
        check_b("t6_awvalid_post", bus.awvalid, 1'b0);
        check_w("t6_rdata_rst", bus.rsp_rdata, 32'h0);
        step();

        // Random traffic against the model
        for (int i = 0; i < 150; i++) begin
            ar_dly = $urandom_range(0, 3); aw_dly = $urandom_range(0, 3);
            w_dly  = $urandom_range(0, 3); r_dly  = $urandom_range(0, 3);
            b_dly  = $urandom_range(0, 3);
            nxt_rdata = $urandom;
            nxt_rresp = 2'($urandom_range(0, 3));
            nxt_bresp = 2'($urandom_range(0, 3));
            s = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'b0000;
            issue($urandom & 32'hFFFF_FFFC, $urandom, s, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) step();
        end
        n = 0;
        while (n < 300) begin
            @(negedge clk);
            if (bus.req_ready) break;
            n++;
        end
        check_b("drain_idle", bus.req_ready, 1'b1);
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
